dec3x8_seq: RTL and testbench

DEC3X8_SEQ -- requirements
Module: dec3x8_seq

---
 rtl/dec3x8_seq.sv | 160 ++++++++++++++++
 tb/tb_dec3x8_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec3x8_seq.sv
// -----------------------------------------------------------------------------
// dec3x8_seq
//   Sequenced 3-to-8 decoder. A load in IDLE captures a start code, a mode and
//   a dwell count. In single-decode mode the code is presented on a one-hot
//   output for hold+1 cycles. In walk mode all eight codes starting at the
//   captured one are presented in turn, each for hold+1 cycles. A normal
//   finish produces a one-cycle done pulse. Dropping E while busy aborts the
//   operation without a done pulse.
//
// Ports
//   clk     in   1       sole clock, rising edge
//   rst     in   1       asynchronous reset, active high
//   E       in   1       block enable (0 aborts / keeps idle)
//   A       in   3       start code to decode
//   load    in   1       start request, sampled only while idle
//   mode    in   1       0 = single decode, 1 = walk all eight codes
//   hold    in   HOLD_W  dwell: each code held hold+1 cycles
//   Y       out  8       registered one-hot decoded output (zero when idle)
//   code_o  out  3       index of the asserted Y bit
//   busy    out  1       high while an operation is running
//   done    out  1       one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module dec3x8_seq #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E,
  input  logic [2:0]        A,
  input  logic              load,
  input  logic              mode,
  input  logic [HOLD_W-1:0] hold,
  output logic [7:0]        Y,
  output logic [2:0]        code_o,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WALK   = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] CNT_ONE = 1;

  // One-hot decode of a 3-bit index.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  // Rotate left by one: bit 7 wraps into bit 0, matching code 7 -> 0.
  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        y_q, y_d;
  logic [2:0]        code_q, code_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [2:0]        a_q, a_d;
  logic              mode_q, mode_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        code_next;
  logic              last_step;

  // The walk has presented all eight codes once the next code would be the
  // captured start code again; single decode always ends after one code.
  assign code_next = code_q + 3'd1;
  assign last_step = !mode_q || (code_next == a_q);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    code_d  = code_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    a_d     = a_q;
    mode_d  = mode_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        y_d    = 8'h00;
        busy_d = 1'b0;
        if (E && load) begin
          a_d     = A;
          mode_d  = mode;
          hold_d  = hold;
          cnt_d   = hold;
          code_d  = A;
          y_d     = onehot8(A);
          busy_d  = 1'b1;
          state_d = mode ? WALK : DECODE;
        end
      end

      DECODE, WALK: begin
        if (!E) begin
          // Abort: drop straight to idle, no done pulse.
          state_d = IDLE;
          y_d     = 8'h00;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (last_step) begin
          state_d = IDLE;
          y_d     = 8'h00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          code_d = code_next;
          y_d    = rotl8(y_q);
          cnt_d  = hold_q;
        end
      end

      default: begin
        state_d = IDLE;
        y_d     = 8'h00;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= 8'h00;
      code_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= 3'd0;
      mode_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
    end
  end

  assign Y      = y_q;
  assign code_o = code_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_dec3x8_seq.sv
// -----------------------------------------------------------------------------
// tb_dec3x8_seq
//   Directed bench for dec3x8_seq. Expected per-cycle outputs are pushed to a
//   scoreboard queue as each operation is started and popped one per clock,
//   sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dec3x8_seq;

  localparam int HOLD_W = 4;

  logic              clk;
  logic              rst;
  logic              E;
  logic [2:0]        A;
  logic              load;
  logic              mode;
  logic [HOLD_W-1:0] hold;
  logic [7:0]        Y;
  logic [2:0]        code_o;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] code;
    logic       busy;
    logic       done;
    logic       chk_code;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  dec3x8_seq #(.HOLD_W(HOLD_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .E      (E),
    .A      (A),
    .load   (load),
    .mode   (mode),
    .hold   (hold),
    .Y      (Y),
    .code_o (code_o),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_idle(input int n, input logic code_zero);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{y: 8'h00, code: 3'd0, busy: 1'b0, done: 1'b0, chk_code: code_zero};
      sb.push_back(e);
    end
  endtask

  task automatic push_code(input logic [2:0] c, input int n);
    exp_t e;
    logic [7:0] one;
    one = 8'h01;
    for (int i = 0; i < n; i++) begin
      e = '{y: one << c, code: c, busy: 1'b1, done: 1'b0, chk_code: 1'b1};
      sb.push_back(e);
    end
  endtask

  task automatic push_done();
    exp_t e;
    e = '{y: 8'h00, code: 3'd0, busy: 1'b0, done: 1'b1, chk_code: 1'b0};
    sb.push_back(e);
  endtask

  // Whole operation: one code (or eight in walk mode) each held hold+1 cycles,
  // followed by the done cycle.
  task automatic push_op(input logic [2:0] a, input logic walk, input int h);
    logic [2:0] c;
    c = a;
    for (int k = 0; k < (walk ? 8 : 1); k++) begin
      push_code(c, h + 1);
      c = c + 3'd1;
    end
    push_done();
  endtask

  task automatic run(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s_sb_empty observed=0 expected=nonempty", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, "_Y"},    {24'd0, Y},    {24'd0, e.y});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e.busy});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, e.done});
        if (e.chk_code)
          chk({tag, "_code"}, {29'd0, code_o}, {29'd0, e.code});
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held with a load request present: outputs stay cleared.
    rst  = 1'b1;
    E    = 1'b1;
    load = 1'b1;
    A    = 3'd5;
    mode = 1'b0;
    hold = 4'd2;
    #2;
    chk("rst_async_Y",    {24'd0, Y},    32'h0);
    chk("rst_async_busy", {31'd0, busy}, 32'h0);
    chk("rst_async_done", {31'd0, done}, 32'h0);
    push_idle(3, 1'b1);
    run(3, "reset");

    // First load after release honoured at first edge; single decode A=5 hold=2.
    rst = 1'b0;
    push_op(3'd5, 1'b0, 2);
    run(1, "single");
    load = 1'b0;
    run(3, "single");
    push_idle(1, 1'b0);
    run(1, "single_idle");

    // Walk with wrap: A=6, hold=0.
    A = 3'd6; mode = 1'b1; hold = 4'd0; load = 1'b1;
    push_op(3'd6, 1'b1, 0);
    run(1, "walk");
    load = 1'b0;
    run(8, "walk");

    // Walk A=0 hold=1 with a stray load (different A/mode/hold) mid-walk.
    A = 3'd0; mode = 1'b1; hold = 4'd1; load = 1'b1;
    push_op(3'd0, 1'b1, 1);
    run(1, "ignload");
    load = 1'b0;
    run(3, "ignload");
    A = 3'd3; mode = 1'b0; hold = 4'd5; load = 1'b1;
    run(1, "ignload");
    load = 1'b0;
    run(12, "ignload");
    push_idle(1, 1'b0);
    run(1, "ignload_idle");

    // Abort: E dropped during the third code of a walk (A=0, hold=3).
    A = 3'd0; mode = 1'b1; hold = 4'd3; load = 1'b1;
    push_code(3'd0, 4);
    push_code(3'd1, 4);
    push_code(3'd2, 1);
    run(1, "abort");
    load = 1'b0;
    run(8, "abort");
    E = 1'b0;
    push_idle(3, 1'b0);
    run(3, "abort_after");

    // Load with E=0 is ignored.
    load = 1'b1; A = 3'd4; mode = 1'b0; hold = 4'd0;
    push_idle(2, 1'b0);
    run(2, "load_noE");
    load = 1'b0;
    E = 1'b1;

    // Back-to-back: load held high, A=1, hold=0, single decode.
    A = 3'd1; mode = 1'b0; hold = 4'd0; load = 1'b1;
    push_op(3'd1, 1'b0, 0);
    push_op(3'd1, 1'b0, 0);
    push_op(3'd1, 1'b0, 0);
    run(6, "b2b");
    load = 1'b0;
    push_idle(1, 1'b0);
    run(1, "b2b_idle");

    // Maximum dwell: hold=15 gives 16 cycles on the code.
    A = 3'd7; mode = 1'b0; hold = 4'd15; load = 1'b1;
    push_op(3'd7, 1'b0, 15);
    run(1, "maxhold");
    load = 1'b0;
    run(16, "maxhold");

    // Reset mid-walk: operation discarded, no done afterwards.
    A = 3'd2; mode = 1'b1; hold = 4'd1; load = 1'b1;
    push_code(3'd2, 2);
    push_code(3'd3, 1);
    run(1, "rstwalk");
    load = 1'b0;
    run(2, "rstwalk");
    #2;
    rst = 1'b1;
    #1;
    chk("rstwalk_async_Y",    {24'd0, Y},      32'h0);
    chk("rstwalk_async_busy", {31'd0, busy},   32'h0);
    chk("rstwalk_async_code", {29'd0, code_o}, 32'h0);
    push_idle(2, 1'b1);
    run(2, "rstwalk_hold");
    rst = 1'b0;
    push_idle(3, 1'b1);
    run(3, "rstwalk_after");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
